// File: rtl/feature_pad_streamer.sv
// Streams a zero-padded feature frame from per-group FIFOs in raster order.
// It also produces a conv_valid strobe aligned to the downstream convolution pipeline.
module feature_pad_streamer #(
  parameter int FEATURE_WIDTH = 16,
  parameter int CH_PER_GROUP  = 8,
  parameter int GROUP_NUM     = 2,
  parameter int FIFO_DEPTH    = 64,
  parameter int PIPE_DELAY    = 10
) (
  input  logic                                      system_clk,
  input  logic                                      rst_n,
  input  logic                                      load_begin,
  input  logic                                      compute_begin,
  input  logic [9:0]                                row_size,
  input  logic [9:0]                                col_size,
  input  logic [2:0]                                pad_top,
  input  logic [2:0]                                pad_bottom,
  input  logic [2:0]                                pad_left,
  input  logic [2:0]                                pad_right,
  input  logic [2:0]                                kernel_size,
  input  logic [1:0]                                stride_log2,
  input  logic [GROUP_NUM-1:0]                      group_en,
  input  logic [CH_PER_GROUP*FEATURE_WIDTH-1:0]     in_data,
  input  logic [GROUP_NUM-1:0]                      in_valid,
  output logic [GROUP_NUM-1:0]                      in_ready,
  output logic [GROUP_NUM*CH_PER_GROUP*FEATURE_WIDTH-1:0] out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      conv_valid,
  output logic                                      compute_finish,
  output logic                                      busy,
  output logic                                      cfg_err
);
  localparam int GW  = CH_PER_GROUP * FEATURE_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(PIPE_DELAY + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]           state;
  logic [9:0]           rs_q, cs_q;
  logic [2:0]           pt_q, pb_q, pl_q, pr_q, k_q;
  logic [1:0]           sl_q;
  logic [GROUP_NUM-1:0] gen_q;
  logic [10:0]          row_q, col_q;
  logic [FCW-1:0]       flush_cnt;
  logic                 pad_q, flag_q;
  logic [GROUP_NUM-1:0] full, empty;
  logic [GW-1:0]        fifo_q [GROUP_NUM];
  logic [PIPE_DELAY-1:0] conv_sr;

  logic [10:0] pr_in, pc_in, pr_ext, pc_ext, km1, smask, row_off, col_off;
  logic        cfg_bad, is_pad, all_avail, issue, flag, row_last, col_last;

  assign pr_in   = {1'b0, row_size} + {8'b0, pad_top} + {8'b0, pad_bottom};
  assign pc_in   = {1'b0, col_size} + {8'b0, pad_left} + {8'b0, pad_right};
  assign cfg_bad = (kernel_size == 3'd0) || ({8'b0, kernel_size} > pr_in) ||
                   ({8'b0, kernel_size} > pc_in);

  assign pr_ext   = {1'b0, rs_q} + {8'b0, pt_q} + {8'b0, pb_q};
  assign pc_ext   = {1'b0, cs_q} + {8'b0, pl_q} + {8'b0, pr_q};
  assign row_last = (row_q == pr_ext - 11'd1);
  assign col_last = (col_q == pc_ext - 11'd1);
  assign is_pad   = (row_q < {8'b0, pt_q}) || (row_q >= {8'b0, pt_q} + {1'b0, rs_q}) ||
                    (col_q < {8'b0, pl_q}) || (col_q >= {8'b0, pl_q} + {1'b0, cs_q});

  always_comb begin
    all_avail = 1'b1;
    for (int i = 0; i < GROUP_NUM; i++)
      if (gen_q[i] && empty[i]) all_avail = 1'b0;
  end

  assign issue = (state == ST_RUN) && out_ready && (is_pad || all_avail);

  // Stride phase is measured from the first full kernel window, not from the frame origin.
  assign km1     = {8'b0, k_q} - 11'd1;
  assign smask   = (11'd1 << sl_q) - 11'd1;
  assign row_off = row_q - km1;
  assign col_off = col_q - km1;
  assign flag    = (row_q >= km1) && (col_q >= km1) &&
                   ((row_off & smask) == 11'd0) && ((col_off & smask) == 11'd0);

  for (genvar g = 0; g < GROUP_NUM; g++) begin : g_fifo
    logic [GW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign full[g]  = (cnt == (AW+1)'(FIFO_DEPTH));
    assign empty[g] = (cnt == '0);
    assign push     = in_valid[g] && !full[g] && !load_begin;
    assign pop      = issue && !is_pad && gen_q[g];
    assign in_ready[g] = !full[g];

    always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (load_begin) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop)  rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end

    always_ff @(posedge system_clk)
      if (push) mem[wp] <= in_data;

    always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n)   fifo_q[g] <= '0;
      else if (pop) fifo_q[g] <= mem[rp];
    end

    assign out_data[g*GW +: GW] = (out_valid && !pad_q && gen_q[g]) ? fifo_q[g] : '0;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rs_q           <= '0;
      cs_q           <= '0;
      pt_q           <= '0;
      pb_q           <= '0;
      pl_q           <= '0;
      pr_q           <= '0;
      k_q            <= '0;
      sl_q           <= '0;
      gen_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      flush_cnt      <= '0;
      out_valid      <= 1'b0;
      pad_q          <= 1'b0;
      flag_q         <= 1'b0;
      cfg_err        <= 1'b0;
      compute_finish <= 1'b0;
    end else begin
      cfg_err        <= 1'b0;
      compute_finish <= 1'b0;
      out_valid      <= issue;
      pad_q          <= is_pad;
      flag_q         <= flag;
      case (state)
        ST_IDLE: begin
          if (compute_begin) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              rs_q  <= row_size;
              cs_q  <= col_size;
              pt_q  <= pad_top;
              pb_q  <= pad_bottom;
              pl_q  <= pad_left;
              pr_q  <= pad_right;
              k_q   <= kernel_size;
              sl_q  <= stride_log2;
              gen_q <= group_en;
              row_q <= '0;
              col_q <= '0;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (compute_begin) cfg_err <= 1'b1;
          if (issue) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                state     <= ST_FLUSH;
                flush_cnt <= '0;
              end else begin
                row_q <= row_q + 11'd1;
              end
            end else begin
              col_q <= col_q + 11'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (compute_begin) cfg_err <= 1'b1;
          if (flush_cnt == FCW'(PIPE_DELAY)) begin
            state          <= ST_IDLE;
            compute_finish <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_sr <= '0;
    end else begin
      conv_sr[0] <= out_valid && flag_q;
      for (int i = 1; i < PIPE_DELAY; i++) conv_sr[i] <= conv_sr[i-1];
    end
  end

  assign conv_valid = conv_sr[PIPE_DELAY-1];
  assign busy       = (state == ST_RUN) || (state == ST_FLUSH);

endmodule

// File: tb/tb_feature_pad_streamer.sv
// Directed bench for feature_pad_streamer: padding, stride, underflow, backpressure,
// full FIFO, config errors and mid-frame reset, with hand-computed expectations.
module tb_feature_pad_streamer;
  localparam int GW = 128;
  localparam int PD = 10;

  logic         system_clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load_begin = 1'b0, compute_begin = 1'b0;
  logic [9:0]   row_size = '0, col_size = '0;
  logic [2:0]   pad_top = '0, pad_bottom = '0, pad_left = '0, pad_right = '0;
  logic [2:0]   kernel_size = '0;
  logic [1:0]   stride_log2 = '0;
  logic [1:0]   group_en = '0;
  logic [GW-1:0] in_data = '0;
  logic [1:0]   in_valid = '0;
  logic [1:0]   in_ready;
  logic [2*GW-1:0] out_data;
  logic         out_valid, out_ready = 1'b1, conv_valid, compute_finish, busy, cfg_err;

  feature_pad_streamer dut (
    .system_clk(system_clk), .rst_n(rst_n), .load_begin(load_begin),
    .compute_begin(compute_begin), .row_size(row_size), .col_size(col_size),
    .pad_top(pad_top), .pad_bottom(pad_bottom), .pad_left(pad_left), .pad_right(pad_right),
    .kernel_size(kernel_size), .stride_log2(stride_log2), .group_en(group_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .conv_valid(conv_valid),
    .compute_finish(compute_finish), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 system_clk = ~system_clk;

  int nvec = 0, nfail = 0;
  int cyc = 0, ov_cnt = 0, cv_cnt = 0, cf_cnt = 0, cf_cyc = 0, last_ov_cyc = 0, nz_idle = 0;
  int mon_idx;
  logic [2*GW-1:0] outq[$];
  int ov_cyc_q[$];
  int cv_idx[$];
  bit bp = 1'b0;

  always @(negedge system_clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid) begin
        outq.push_back(out_data);
        ov_cyc_q.push_back(cyc);
        ov_cnt++;
        last_ov_cyc = cyc;
      end else if (out_data != '0) begin
        nz_idle++;
      end
      if (conv_valid) begin
        mon_idx = -1;
        foreach (ov_cyc_q[i]) if (ov_cyc_q[i] == cyc - PD) mon_idx = i;
        cv_idx.push_back(mon_idx);
        cv_cnt++;
      end
      if (compute_finish) begin
        cf_cnt++;
        cf_cyc = cyc;
      end
    end
  end

  function automatic logic [GW-1:0] word(int g, int i);
    return {4{8'(g + 1), 8'hC5, 16'(i)}};
  endfunction

  // Expected out_data for the n-th issued position of a frame.
  function automatic logic [2*GW-1:0] exp_out(int n, int rs, int cs, int pt, int pl, int pr,
                                               logic [1:0] gen, int base);
    int pc, r, c, idx;
    logic [2*GW-1:0] v;
    pc = pl + cs + pr;
    r = n / pc;
    c = n % pc;
    v = '0;
    if (r >= pt && r < pt + rs && c >= pl && c < pl + cs) begin
      idx = (r - pt) * cs + (c - pl);
      if (gen[0]) v[GW-1:0]    = word(0, base + idx);
      if (gen[1]) v[2*GW-1:GW] = word(1, base + idx);
    end
    return v;
  endfunction

  task automatic chk(string tag, logic [2*GW-1:0] got, logic [2*GW-1:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic do_load();
    load_begin = 1'b1;
    tick(1);
    load_begin = 1'b0;
  endtask

  task automatic write_words(int g, int base, int n);
    for (int i = 0; i < n; i++) begin
      in_data  = word(g, base + i);
      in_valid = 2'(1 << g);
      tick(1);
    end
    in_valid = '0;
  endtask

  task automatic start_frame(int rs, int cs, int pt, int pb, int pl, int pr, int k, int sl,
                             logic [1:0] gen);
    row_size = 10'(rs); col_size = 10'(cs);
    pad_top = 3'(pt); pad_bottom = 3'(pb); pad_left = 3'(pl); pad_right = 3'(pr);
    kernel_size = 3'(k); stride_log2 = 2'(sl); group_en = gen;
    compute_begin = 1'b1;
    tick(1);
    compute_begin = 1'b0;
  endtask

  task automatic clear_mon();
    outq.delete(); ov_cyc_q.delete(); cv_idx.delete();
    ov_cnt = 0; cv_cnt = 0; cf_cnt = 0;
  endtask

  task automatic wait_finish(int budget, output bit timed_out);
    int start;
    start = cf_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bp) out_ready = ~out_ready;
      if (cf_cnt != start) begin
        timed_out = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  function automatic int zero_count();
    int z = 0;
    foreach (outq[i]) if (outq[i] == '0) z++;
    return z;
  endfunction

  function automatic logic [2*GW-1:0] outq_at(int n);
    return (n < outq.size()) ? outq[n] : 'x;
  endfunction

  initial begin
    bit to;
    int snap;
    int exp_cv [4];
    exp_cv = '{14, 16, 26, 28};

    #2 rst_n = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", {conv_valid, compute_finish, cfg_err}, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 4x4 frame, pad 1 all round, K=3 S=1, both groups
    do_load();
    write_words(0, 'h100, 16);
    write_words(1, 'h100, 16);
    chk("t1_in_ready", in_ready, 2'b11);
    clear_mon();
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    wait_finish(500, to);
    chk("t1_timeout", to, 1'b0);
    chk("t1_ov_cnt", ov_cnt, 36);
    chk("t1_zero_cnt", zero_count(), 20);
    for (int n = 0; n < 36; n++) chk("t1_data", outq_at(n), exp_out(n, 4, 4, 1, 1, 1, 2'b11, 'h100));
    chk("t1_cv_cnt", cv_cnt, 16);
    chk("t1_cf_delay", cf_cyc - last_ov_cyc, 11);
    chk("t1_cf_cnt", cf_cnt, 1);
    chk("t1_busy_end", busy, 1'b0);

    // 5x5 frame, bottom/right pad 1, K=3 S=2, group 0 only
    do_load();
    write_words(0, 'h200, 25);
    clear_mon();
    start_frame(5, 5, 0, 1, 0, 1, 3, 1, 2'b01);
    wait_finish(500, to);
    chk("t2_timeout", to, 1'b0);
    chk("t2_ov_cnt", ov_cnt, 36);
    for (int n = 0; n < 36; n++) chk("t2_data", outq_at(n), exp_out(n, 5, 5, 0, 0, 1, 2'b01, 'h200));
    chk("t2_cv_cnt", cv_cnt, 4);
    for (int i = 0; i < 4; i++) chk("t2_cv_pos", (i < cv_idx.size()) ? cv_idx[i] : -1, exp_cv[i]);

    // Group 1 starved: only the leading pad positions may issue
    do_load();
    write_words(0, 'h300, 16);
    clear_mon();
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    tick(30);
    chk("t3_stall_ov", ov_cnt, 7);
    chk("t3_stall_busy", busy, 1'b1);
    write_words(1, 'h300, 16);
    wait_finish(500, to);
    chk("t3_timeout", to, 1'b0);
    chk("t3_ov_cnt", ov_cnt, 36);
    for (int n = 0; n < 36; n++) chk("t3_data", outq_at(n), exp_out(n, 4, 4, 1, 1, 1, 2'b11, 'h300));

    // Same frame with out_ready toggling every cycle
    do_load();
    write_words(0, 'h400, 16);
    write_words(1, 'h400, 16);
    clear_mon();
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    bp = 1'b1;
    wait_finish(500, to);
    bp = 1'b0;
    chk("t3b_timeout", to, 1'b0);
    chk("t3b_ov_cnt", ov_cnt, 36);
    for (int n = 0; n < 36; n++) chk("t3b_data", outq_at(n), exp_out(n, 4, 4, 1, 1, 1, 2'b11, 'h400));
    chk("t3b_cv_cnt", cv_cnt, 16);
    chk("t3b_cf_delay", cf_cyc - last_ov_cyc, 11);

    // Fill group 0 past its depth, then drain all 64 entries
    do_load();
    write_words(0, 'h500, 64);
    chk("t4_full_ready", in_ready, 2'b10);
    write_words(0, 'h540, 1);
    chk("t4_drop_ready", in_ready, 2'b10);
    clear_mon();
    start_frame(8, 8, 0, 0, 0, 0, 1, 0, 2'b01);
    wait_finish(500, to);
    chk("t4_timeout", to, 1'b0);
    chk("t4_ov_cnt", ov_cnt, 64);
    for (int n = 0; n < 64; n++) chk("t4_data", outq_at(n), exp_out(n, 8, 8, 0, 0, 0, 2'b01, 'h500));
    chk("t4_cv_cnt", cv_cnt, 64);
    chk("t4_ready_end", in_ready, 2'b11);

    // compute_begin while busy, then an oversized kernel
    do_load();
    write_words(0, 'h600, 16);
    write_words(1, 'h600, 16);
    clear_mon();
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    chk("t5_first_err", cfg_err, 1'b0);
    tick(5);
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    chk("t5_busy_err", cfg_err, 1'b1);
    chk("t5_busy_still", busy, 1'b1);
    tick(1);
    chk("t5_err_pulse", cfg_err, 1'b0);
    wait_finish(500, to);
    chk("t5_timeout", to, 1'b0);
    chk("t5_ov_cnt", ov_cnt, 36);
    chk("t5_cf_cnt", cf_cnt, 1);
    for (int n = 0; n < 36; n++) chk("t5_data", outq_at(n), exp_out(n, 4, 4, 1, 1, 1, 2'b11, 'h600));
    clear_mon();
    start_frame(4, 4, 0, 0, 0, 0, 7, 0, 2'b11);
    chk("t5_k7_err", cfg_err, 1'b1);
    chk("t5_k7_busy", busy, 1'b0);
    tick(20);
    chk("t5_k7_idle", busy, 1'b0);
    chk("t5_k7_ov", ov_cnt, 0);

    // Reset in the middle of a streaming frame
    do_load();
    write_words(0, 'h700, 16);
    write_words(1, 'h700, 16);
    clear_mon();
    start_frame(4, 4, 1, 1, 1, 1, 3, 0, 2'b11);
    tick(15);
    chk("t6_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_out_data", out_data, '0);
    chk("t6_ctrl", {conv_valid, compute_finish, busy, cfg_err}, 4'b0000);
    chk("t6_in_ready", in_ready, 2'b11);
    tick(3);
    rst_n = 1'b1;
    snap = ov_cnt;
    tick(40);
    chk("t6_no_finish", cf_cnt, 0);
    chk("t6_no_output", ov_cnt, snap);
    chk("t6_idle", busy, 1'b0);

    chk("idle_data_zero", nz_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
